ctrl_pipe_unit: RTL and testbench

//  Registered ID-stage control unit for the five-stage RV32I core. Decodes id_opcode/func3/func7 into the EX control

---
 rtl/ctrl_pipe_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: ID-stage decoder and ID/EX control register for the five-stage RV32I core.
// Define RV32M_EN to add RV32M decode and the multi-cycle EX hold counter.
module ctrl_pipe_unit #(
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_func3,
  input  logic [6:0]        id_func7,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [4:0]        ex_alu_opt,
  output logic              ex_a_pc,
  output logic [1:0]        ex_b_sel,
  output logic              ex_reg_we,
  output logic              ex_wb_mem,
  output logic [1:0]        ex_ram_wr,
  output logic [2:0]        ex_ram_ld,
  output logic [1:0]        ex_pc_cond,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_illegal,
  output logic              ex_busy
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SRA  = 5'd9;
  localparam logic [4:0] ALU_JALR = 5'd10;
  localparam logic [4:0] ALU_BEQ  = 5'd11;
  localparam logic [4:0] ALU_BNE  = 5'd12;
  localparam logic [4:0] ALU_BLT  = 5'd13;
  localparam logic [4:0] ALU_BGE  = 5'd14;
  localparam logic [4:0] ALU_BLTU = 5'd15;
  localparam logic [4:0] ALU_BGEU = 5'd16;
  localparam logic [4:0] ALU_LUI  = 5'd17;
  localparam logic [4:0] ALU_MUL  = 5'd18;

  typedef struct packed {
    logic              valid;
    logic [4:0]        alu_opt;
    logic              a_pc;
    logic [1:0]        b_sel;
    logic              reg_we;
    logic              wb_mem;
    logic [1:0]        ram_wr;
    logic [2:0]        ram_ld;
    logic [1:0]        pc_cond;
    logic [REG_AW-1:0] rd;
    logic              illegal;
  } ctrl_t;

  ctrl_t      dec;
  ctrl_t      ex_q;
  logic [4:0] alu_base;
  logic       use1;
  logic       use2;
  logic       lu;
`ifdef RV32M_EN
  logic       dec_is_m;
  logic       dec_is_div;
`endif

  // Shared func3 -> ALU op map for OP and OP-IMM; SUB only exists in register form.
  always_comb begin
    case (id_func3)
      3'b000:  alu_base = (id_opcode == OPC_OP && id_func7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = ALU_SLT;
      3'b011:  alu_base = ALU_SLTU;
      3'b100:  alu_base = ALU_XOR;
      3'b101:  alu_base = id_func7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  end

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.rd    = id_rd;
`ifdef RV32M_EN
    dec_is_m   = 1'b0;
    dec_is_div = 1'b0;
`endif
    case (id_opcode)
      OPC_LUI: begin
        dec.b_sel = 2'b01; dec.alu_opt = ALU_LUI; dec.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a_pc = 1'b1; dec.b_sel = 2'b01; dec.reg_we = 1'b1;
      end
      OPC_JAL: begin
        dec.a_pc = 1'b1; dec.b_sel = 2'b11; dec.reg_we = 1'b1; dec.pc_cond = 2'b10;
      end
      OPC_JALR: begin
        dec.b_sel = 2'b01; dec.alu_opt = ALU_JALR; dec.reg_we = 1'b1; dec.pc_cond = 2'b11;
        dec.illegal = (id_func3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.pc_cond = 2'b01;
        case (id_func3)
          3'b000:  dec.alu_opt = ALU_BEQ;
          3'b001:  dec.alu_opt = ALU_BNE;
          3'b100:  dec.alu_opt = ALU_BLT;
          3'b101:  dec.alu_opt = ALU_BGE;
          3'b110:  dec.alu_opt = ALU_BLTU;
          3'b111:  dec.alu_opt = ALU_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.b_sel = 2'b01; dec.reg_we = 1'b1; dec.wb_mem = 1'b1;
        case (id_func3)
          3'b000:  dec.ram_ld = 3'b111;
          3'b001:  dec.ram_ld = 3'b110;
          3'b010:  dec.ram_ld = 3'b001;
          3'b100:  dec.ram_ld = 3'b011;
          3'b101:  dec.ram_ld = 3'b010;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.b_sel = 2'b01;
        case (id_func3)
          3'b000:  dec.ram_wr = 2'b11;
          3'b001:  dec.ram_wr = 2'b10;
          3'b010:  dec.ram_wr = 2'b01;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.b_sel = 2'b01; dec.alu_opt = alu_base; dec.reg_we = 1'b1;
      end
      OPC_OP: begin
        dec.reg_we = 1'b1;
        if (id_func7 == 7'b0000001) begin
`ifdef RV32M_EN
          dec.alu_opt = ALU_MUL + {2'b00, id_func3};
          dec_is_m    = 1'b1;
          dec_is_div  = id_func3[2];
`else
          dec.illegal = 1'b1;
`endif
        end else begin
          dec.alu_opt = alu_base;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal encoding travels down EX as a flagged bubble with no side effects.
    if (dec.illegal) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
`ifdef RV32M_EN
      dec_is_m    = 1'b0;
      dec_is_div  = 1'b0;
`endif
    end
  end

  assign use1 = !(id_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign use2 = id_opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};

  assign lu = ex_q.valid && (ex_q.ram_ld != 3'b000) && (ex_q.rd != '0) && id_valid &&
              ((use1 && id_rs1 == ex_q.rd) || (use2 && id_rs2 == ex_q.rd));

  // ID hands its instruction to EX on an edge where id_valid=1, id_stall=0 and ex_flush=0;
  // while id_stall=1 the PC and IF/ID register hold so the same instruction is offered again.
  assign id_stall = (ex_busy || lu) && !ex_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (ex_flush) begin
      ex_q <= '0;
    end else if (!ex_busy) begin
      ex_q <= (lu || !id_valid) ? '0 : dec;
    end
  end

`ifdef RV32M_EN
  localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;

  // Counts the extra cycles an M op keeps EX occupied after it is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (ex_flush) begin
      hold_cnt <= '0;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end else if (!lu && id_valid && dec_is_m) begin
      hold_cnt <= dec_is_div ? DIV_LD : MUL_LD;
    end
  end

  assign ex_busy = (hold_cnt != '0);
`else
  assign ex_busy = 1'b0;
`endif

  assign ex_valid   = ex_q.valid;
  assign ex_alu_opt = ex_q.alu_opt;
  assign ex_a_pc    = ex_q.a_pc;
  assign ex_b_sel   = ex_q.b_sel;
  assign ex_reg_we  = ex_q.reg_we;
  assign ex_wb_mem  = ex_q.wb_mem;
  assign ex_ram_wr  = ex_q.ram_wr;
  assign ex_ram_ld  = ex_q.ram_ld;
  assign ex_pc_cond = ex_q.pc_cond;
  assign ex_rd      = ex_q.rd;
  assign ex_illegal = ex_q.illegal;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: directed scenarios followed by random instruction streams,
// each cycle compared against a table-driven reference of the ID/EX control register.
`timescale 1ns/1ps
module tb_ctrl_pipe_unit;

  localparam int AW    = 5;
  localparam int MUL_C = 2;
  localparam int DIV_C = 4;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] OP    = 7'b0110011;

  typedef struct packed {
    logic          valid;
    logic [4:0]    opt;
    logic          a_pc;
    logic [1:0]    b_sel;
    logic          we;
    logic          wb_mem;
    logic [1:0]    wr;
    logic [2:0]    ld;
    logic [1:0]    pc;
    logic [AW-1:0] rd;
    logic          illegal;
  } bund_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [6:0]    id_opcode = '0;
  logic [2:0]    id_func3 = '0;
  logic [6:0]    id_func7 = '0;
  logic [AW-1:0] id_rs1 = '0;
  logic [AW-1:0] id_rs2 = '0;
  logic [AW-1:0] id_rd = '0;
  logic          ex_flush = 1'b0;
  logic          id_stall, ex_valid, ex_a_pc, ex_reg_we, ex_wb_mem, ex_illegal, ex_busy;
  logic [4:0]    ex_alu_opt;
  logic [1:0]    ex_b_sel, ex_ram_wr, ex_pc_cond;
  logic [2:0]    ex_ram_ld;
  logic [AW-1:0] ex_rd;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.REG_AW(AW), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_func3(id_func3), .id_func7(id_func7), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .ex_flush(ex_flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_alu_opt(ex_alu_opt), .ex_a_pc(ex_a_pc), .ex_b_sel(ex_b_sel),
    .ex_reg_we(ex_reg_we), .ex_wb_mem(ex_wb_mem), .ex_ram_wr(ex_ram_wr),
    .ex_ram_ld(ex_ram_ld), .ex_pc_cond(ex_pc_cond), .ex_rd(ex_rd),
    .ex_illegal(ex_illegal), .ex_busy(ex_busy)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  bund_t       m_ex = '0;
  int          m_hold = 0;
  logic        last_stall = 1'b0;

  int br_tab[8]  = '{11, 12, -1, -1, 13, 14, 15, 16};
  int ld_tab[8]  = '{7, 6, 1, -1, 3, 2, -1, -1};
  int wr_tab[8]  = '{3, 2, 1, -1, -1, -1, -1, -1};
  int alu_tab[8] = '{0, 5, 6, 7, 4, 8, 3, 2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observed();
    bund_t o;
    o = '{ex_valid, ex_alu_opt, ex_a_pc, ex_b_sel, ex_reg_we, ex_wb_mem,
          ex_ram_wr, ex_ram_ld, ex_pc_cond, ex_rd, ex_illegal};
    return 32'(o);
  endfunction

  // What EX should hold after taking the current ID instruction, plus extra EX cycles.
  task automatic ref_decode(output bund_t b, output int hold);
    int f3;
    bit legal;
    f3 = int'(id_func3);
    legal = 1'b1;
    b = '0;
    hold = 0;
    b.valid = 1'b1;
    b.rd = id_rd;
    if (id_opcode == LUI) begin
      b.b_sel = 2'd1; b.opt = 5'd17; b.we = 1'b1;
    end else if (id_opcode == AUIPC) begin
      b.a_pc = 1'b1; b.b_sel = 2'd1; b.we = 1'b1;
    end else if (id_opcode == JAL) begin
      b.a_pc = 1'b1; b.b_sel = 2'd3; b.we = 1'b1; b.pc = 2'd2;
    end else if (id_opcode == JALR) begin
      legal = (f3 == 0);
      b.b_sel = 2'd1; b.opt = 5'd10; b.we = 1'b1; b.pc = 2'd3;
    end else if (id_opcode == BR) begin
      legal = (br_tab[f3] >= 0);
      b.opt = 5'(br_tab[f3]); b.pc = 2'd1;
    end else if (id_opcode == LOAD) begin
      legal = (ld_tab[f3] >= 0);
      b.b_sel = 2'd1; b.we = 1'b1; b.wb_mem = 1'b1; b.ld = 3'(ld_tab[f3]);
    end else if (id_opcode == STORE) begin
      legal = (wr_tab[f3] >= 0);
      b.b_sel = 2'd1; b.wr = 2'(wr_tab[f3]);
    end else if (id_opcode == OPIMM) begin
      b.b_sel = 2'd1; b.we = 1'b1;
      b.opt = (f3 == 5 && id_func7[5]) ? 5'd9 : 5'(alu_tab[f3]);
    end else if (id_opcode == OP) begin
      b.we = 1'b1;
      if (id_func7 == 7'b0000001) begin
`ifdef RV32M_EN
        b.opt = 5'(18 + f3);
        hold = (f3 < 4) ? MUL_C - 1 : DIV_C - 1;
`else
        legal = 1'b0;
`endif
      end else if (f3 == 0 && id_func7[5]) b.opt = 5'd1;
      else if (f3 == 5 && id_func7[5]) b.opt = 5'd9;
      else b.opt = 5'(alu_tab[f3]);
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin
      b = '0; b.valid = 1'b1; b.illegal = 1'b1; hold = 0;
    end
  endtask

  function automatic bit model_lu();
    bit u1, u2;
    u1 = !(id_opcode == LUI || id_opcode == AUIPC || id_opcode == JAL);
    u2 = (id_opcode == BR || id_opcode == STORE || id_opcode == OP);
    return m_ex.valid && m_ex.ld != 0 && m_ex.rd != 0 && id_valid &&
           ((u1 && id_rs1 == m_ex.rd) || (u2 && id_rs2 == m_ex.rd));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_instr(input logic [6:0] opc, input int f3, input logic [6:0] f7,
                           input int rs1, input int rs2, input int rd, input logic v);
    id_opcode = opc; id_func3 = 3'(f3); id_func7 = f7;
    id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_rd = AW'(rd); id_valid = v;
  endtask

  // One clock: check the combinational stall mid-cycle, then the registered EX state after the edge.
  task automatic cycle();
    bund_t nb;
    int    nh;
    bit    exp_stall;
    @(negedge clk);
    exp_stall = (m_hold > 0 || model_lu()) && !ex_flush;
    last_stall = exp_stall;
    check("id_stall", 32'(id_stall), 32'(exp_stall));
    check("ex_busy", 32'(ex_busy), 32'(m_hold > 0));
    if (ex_flush) begin
      nb = '0; nh = 0;
    end else if (m_hold > 0) begin
      nb = m_ex; nh = m_hold - 1;
    end else if (model_lu() || !id_valid) begin
      nb = '0; nh = 0;
    end else begin
      ref_decode(nb, nh);
    end
    exp_q.push_back(32'(nb));
    @(posedge clk);
    #1;
    m_ex = nb;
    m_hold = nh;
    check("ex_bundle", observed(), exp_q.pop_front());
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    m_ex = '0;
    m_hold = 0;
    check("rst_bundle", observed(), 32'd0);
    check("rst_busy", 32'(ex_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stalls;
    logic [6:0] opc_tab[11];
    opc_tab = '{LUI, AUIPC, JAL, JALR, BR, LOAD, STORE, OPIMM, OP, OP, 7'h00};

    repeat (2) @(posedge clk);
    #1;
    check("reset_bundle", observed(), 32'd0);
    check("reset_busy", 32'(ex_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x2, x1, imm
    set_instr(OPIMM, 0, 7'h00, 1, 0, 2, 1'b1);
    cycle();
    check("addi_opt", 32'(ex_alu_opt), 32'd0);
    check("addi_bsel", 32'(ex_b_sel), 32'd1);
    check("addi_we", 32'(ex_reg_we), 32'd1);
    check("addi_valid", 32'(ex_valid), 32'd1);

    // lw x5 then add x6,x5,x1: one stall, one bubble, then the add
    set_instr(LOAD, 2, 7'h00, 1, 0, 5, 1'b1);
    cycle();
    set_instr(OP, 0, 7'h00, 5, 1, 6, 1'b1);
    cycle();
    check("lu_stall", 32'(last_stall), 32'd1);
    check("lu_bubble", 32'(ex_valid), 32'd0);
    cycle();
    check("lu_nostall", 32'(last_stall), 32'd0);
    check("lu_add_rd", 32'(ex_rd), 32'd6);
    check("lu_add_valid", 32'(ex_valid), 32'd1);

    // lb x0 followed by a reader of x0: no interlock
    set_instr(LOAD, 0, 7'h00, 1, 0, 0, 1'b1);
    cycle();
    set_instr(OP, 0, 7'h00, 0, 0, 7, 1'b1);
    cycle();
    check("x0_nostall", 32'(last_stall), 32'd0);
    check("x0_add_rd", 32'(ex_rd), 32'd7);

    // div x8, x1, x2 followed by addi
    set_instr(OP, 4, 7'h01, 1, 2, 8, 1'b1);
    cycle();
`ifdef RV32M_EN
    check("div_opt", 32'(ex_alu_opt), 32'd22);
    set_instr(OPIMM, 0, 7'h00, 3, 0, 9, 1'b1);
    stalls = 0;
    for (int i = 0; i < DIV_C - 1; i++) begin
      cycle();
      if (last_stall) stalls++;
    end
    check("div_stalls", 32'(stalls), 32'(DIV_C - 1));
    check("div_held", 32'(ex_alu_opt), 32'd22);
    cycle();
    check("after_div_rd", 32'(ex_rd), 32'd9);
`else
    stalls = 0;
    check("div_illegal", 32'(ex_illegal), 32'd1);
    check("div_noop_we", 32'(ex_reg_we), 32'd0);
`endif

    // flush wins over a load-use interlock
    set_instr(LOAD, 2, 7'h00, 1, 0, 5, 1'b1);
    cycle();
    set_instr(OP, 0, 7'h00, 5, 1, 6, 1'b1);
    ex_flush = 1'b1;
    cycle();
    ex_flush = 1'b0;
    check("flush_nostall", 32'(last_stall), 32'd0);
    check("flush_bubble", 32'(ex_valid), 32'd0);

    // reset in the middle of a long op, then an all-zero opcode
    set_instr(OP, 5, 7'h01, 1, 2, 3, 1'b1);
    cycle();
    set_instr(OPIMM, 0, 7'h00, 1, 0, 4, 1'b1);
    cycle();
    apply_reset();
    set_instr(7'h00, 0, 7'h00, 1, 1, 1, 1'b1);
    cycle();
    check("zero_illegal", 32'(ex_illegal), 32'd1);
    check("zero_we", 32'(ex_reg_we), 32'd0);

    // random instruction stream; ID holds its instruction while stalled
    for (int n = 0; n < 600; n++) begin
      if (!last_stall) begin
        int k;
        logic [6:0] opc;
        logic [6:0] f7;
        k = $urandom_range(0, 11);
        opc = (k == 11) ? 7'($urandom) : opc_tab[k];
        case ($urandom_range(0, 3))
          0:       f7 = 7'h00;
          1:       f7 = 7'h20;
          2:       f7 = 7'h01;
          default: f7 = 7'($urandom);
        endcase
        set_instr(opc, $urandom_range(0, 7), f7, $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 99) < 85));
      end
      ex_flush = ($urandom_range(0, 99) < 8);
      cycle();
    end
    ex_flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
